proc_irq_aggregator: RTL and testbench
======================================

PROC_IRQ_AGGREGATOR -- requirements
Module: proc_irq_aggregator

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, range 1..16: number of interrupt sources (e.g. interval timer irq outputs).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  3  Avalon-MM slave word address.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  16  write data.
REQ-008 SHALL have port readdata  output  16  registered read data.
REQ-009 SHALL have port irq_in  input  NUM_SRC  interrupt requests, synchronous to clk, active-high.
REQ-010 SHALL have port irq  output  1  aggregated interrupt to processor, active-high, registered.

Function
REQ-011 SHALL define write strobe = chipselect && ~write_n; reads are side-effect free.
REQ-012 SHALL map registers: 0 PENDING (R, W1C), 1 MASK (RW), 2 MODE (RW, 1=edge, 0=level), 3 ACTIVE = PENDING & MASK (RO), 4 VECTOR (RO), 5 LOST (RO, write any value clears); 6..7 read 0, writes ignored.
REQ-013 SHALL register readdata: value for address sampled at edge k appears after edge k; bits above NUM_SRC read 0.
REQ-014 SHALL register irq_in once (irq_d) for edge detection.
REQ-015 Edge mode: pending[i] SHALL set after the edge where irq_in[i]=1 and irq_d[i]=0.
REQ-016 Level mode: pending[i] SHALL equal irq_in[i] sampled at the previous edge; W1C has no lasting effect while irq_in[i] is high.
REQ-017 Simultaneous set event and W1C on the same bit SHALL leave the bit set.
REQ-018 Writing MODE SHALL clear pending bits whose mode changes, in that same cycle.
REQ-019 irq SHALL be |(PENDING & MASK) registered: one cycle after pending/mask update; total latency irq_in rise -> irq = 2 cycles.
REQ-020 VECTOR SHALL read bit15 = any ACTIVE bit, bits[3:0] = lowest-index active source, else 0x0000.
REQ-021 irq_in held high in edge mode SHALL produce exactly one pending set until it falls and rises again.

Reset
REQ-022 On reset_n=0, PENDING, MASK, irq_d, LOST, readdata, irq SHALL be 0; MODE SHALL be all-ones (edge).
REQ-023 Reset asserted mid-operation SHALL immediately (asynchronously) drive irq and readdata to 0; sources high at release in edge mode SHALL NOT set pending (irq_d reset to 0 is overridden: first sampled cycle after release only loads irq_d).

Configuration
REQ-024 Macro PROC_IRQ_AGG_LOST_CNT_EN defined: LOST is a 16-bit counter incrementing by the number-agnostic rule +1 per cycle in which any edge-mode rising edge hits an already-pending bit not being cleared that cycle; saturates at 0xFFFF.
REQ-025 Macro undefined: no LOST counter logic; address 5 reads 0, writes ignored.

Structure
REQ-026 Shared package SHALL hold register address constants, data width 16, VECTOR valid-bit position, MAX_SRC=16.
REQ-027 Lowest-index-first priority encoder SHALL be a sub-module named proc_irq_prio_enc (input NUM_SRC bits, output valid + 4-bit index, combinational).

Verification
REQ-028 Reset, read addr 2 -> 0x000F (NUM_SRC=4); addr 0,1,3,4 -> 0x0000; irq=0.
REQ-029 MASK=0x0005, pulse irq_in[2] 1 cycle -> PENDING=0x0004, irq=1 two cycles after pulse, VECTOR=0x8002; write 0x0004 to addr 0 -> irq=0 next cycle.
REQ-030 MODE=0x0000, MASK=0x0001, hold irq_in[0]=1, write 0x0001 to addr 0 -> PENDING stays 0x0001, irq stays 1; drop irq_in[0] -> PENDING=0 after 1 cycle, irq=0 after 2.
REQ-031 irq_in=0x0003 pulse with MASK=0x0003 -> VECTOR=0x8000; clear bit0 -> VECTOR=0x8001.
REQ-032 Same cycle: irq_in[1] rising edge and W1C 0x0002 -> PENDING bit1=1.
REQ-033 With PROC_IRQ_AGG_LOST_CNT_EN: three edges on irq_in[3] without clearing -> LOST=0x0002; write addr 5 -> LOST=0x0000; without macro addr 5 reads 0x0000.

Source files
------------

// File: rtl/proc_irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register map, data width, VECTOR layout.
package proc_irq_aggregator_pkg;

  localparam int DATA_W        = 16;
  localparam int MAX_SRC       = 16;
  localparam int IDX_W         = 4;
  localparam int VEC_VALID_BIT = 15;

  typedef enum logic [2:0] {
    ADDR_PENDING = 3'd0,
    ADDR_MASK    = 3'd1,
    ADDR_MODE    = 3'd2,
    ADDR_ACTIVE  = 3'd3,
    ADDR_VECTOR  = 3'd4,
    ADDR_LOST    = 3'd5
  } reg_addr_e;

endpackage

// File: rtl/proc_irq_aggregator_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator register block.
interface proc_irq_aggregator_if;
  import proc_irq_aggregator_pkg::*;

  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/proc_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder for the VECTOR register.
module proc_irq_prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [3:0]         idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/proc_irq_aggregator.sv
// Interrupt aggregator with PENDING/MASK/MODE/ACTIVE/VECTOR/LOST registers and a registered irq.
// Define PROC_IRQ_AGG_LOST_CNT_EN to build the saturating LOST counter at address 5.
module proc_irq_aggregator
  import proc_irq_aggregator_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  proc_irq_aggregator_if.slave bus,
  input  logic [NUM_SRC-1:0]   irq_in,
  output logic                 irq
);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] irq_in_prev_q;
  logic               armed_q;
  logic               irq_q;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               wr_en, wr_pending, wr_mask, wr_mode;
  logic [NUM_SRC-1:0] src_wdata, w1c, mode_chg, edge_set, active;
  logic               vec_valid;
  logic [IDX_W-1:0]   vec_idx;
  logic [DATA_W-1:0]  lost_val;
  logic               unused_wdata;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr_en && (bus.address == ADDR_PENDING);
  assign wr_mask    = wr_en && (bus.address == ADDR_MASK);
  assign wr_mode    = wr_en && (bus.address == ADDR_MODE);
  assign src_wdata  = bus.writedata[NUM_SRC-1:0];
  assign unused_wdata = ^bus.writedata;

  assign w1c      = wr_pending ? src_wdata : '0;
  assign mode_chg = wr_mode ? (src_wdata ^ mode_q) : '0;
  // Edge detection stays disarmed for the first cycle after reset so lines already high
  // at release are absorbed into irq_in_prev_q instead of looking like fresh edges.
  assign edge_set = irq_in & ~irq_in_prev_q & mode_q & {NUM_SRC{armed_q}};
  assign active   = pending_q & mask_q;
  assign mask_d   = wr_mask ? src_wdata : mask_q;
  assign mode_d   = wr_mode ? src_wdata : mode_q;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign pending_d[gi] = mode_chg[gi] ? 1'b0 :
                           !mode_q[gi]  ? irq_in[gi] :
                           (edge_set[gi] | (pending_q[gi] & ~w1c[gi]));
  end

  proc_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req_i   (active),
    .valid_o (vec_valid),
    .idx_o   (vec_idx)
  );

`ifdef PROC_IRQ_AGG_LOST_CNT_EN
  logic [DATA_W-1:0] lost_q, lost_d;
  logic              lost_hit, wr_lost;

  assign wr_lost  = wr_en && (bus.address == ADDR_LOST);
  // A rising edge on a bit that is already pending and survives this cycle is a lost event.
  assign lost_hit = |(edge_set & pending_q & ~w1c & ~mode_chg);

  always_comb begin
    lost_d = lost_q;
    if (wr_lost) begin
      lost_d = '0;
    end else if (lost_hit && (lost_q != '1)) begin
      lost_d = lost_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lost_q <= '0;
    else          lost_q <= lost_d;
  end

  assign lost_val = lost_q;
`else
  assign lost_val = '0;
`endif

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
      ADDR_MASK:    rdata_d[NUM_SRC-1:0] = mask_q;
      ADDR_MODE:    rdata_d[NUM_SRC-1:0] = mode_q;
      ADDR_ACTIVE:  rdata_d[NUM_SRC-1:0] = active;
      ADDR_VECTOR: begin
        rdata_d[VEC_VALID_BIT] = vec_valid;
        rdata_d[IDX_W-1:0]     = vec_idx;
      end
      ADDR_LOST:    rdata_d = lost_val;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      mask_q        <= '0;
      mode_q        <= '1;
      irq_in_prev_q <= '0;
      armed_q       <= 1'b0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      mode_q        <= mode_d;
      irq_in_prev_q <= irq_in;
      armed_q       <= 1'b1;
      irq_q         <= |active;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_proc_irq_aggregator.sv
// Self-checking bench for proc_irq_aggregator: directed scenarios plus randomized traffic vs a model.
module tb_proc_irq_aggregator;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NS-1:0] irq_in;
  logic          irq;

  int errors = 0;
  int checks = 0;

  proc_irq_aggregator_if bus_if ();

  proc_irq_aggregator #(.NUM_SRC(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: register contents as seen by software.
  logic [NS-1:0] m_pend, m_mask, m_mode, m_prev;
  bit            m_armed;
  int            m_lost;
  int            m_hits;
  bit            m_irq;
  logic [15:0]   m_rdata;

  function automatic logic [15:0] model_view(logic [2:0] a);
    logic [15:0]   r;
    logic [NS-1:0] act;
    r   = 16'h0000;
    act = m_pend & m_mask;
    case (a)
      3'd0: r = 16'(m_pend);
      3'd1: r = 16'(m_mask);
      3'd2: r = 16'(m_mode);
      3'd3: r = 16'(act);
      3'd4: begin
        for (int i = 0; i < NS; i++) begin
          if (act[i]) begin
            r = 16'h8000 | 16'(i);
            break;
          end
        end
      end
`ifdef PROC_IRQ_AGG_LOST_CNT_EN
      3'd5: r = 16'(m_lost);
`endif
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Advances the model across the next rising edge using the inputs currently driven.
  task automatic model_step();
    logic [NS-1:0] np;
    bit            we, hit;
    we      = bus_if.chipselect && !bus_if.write_n;
    m_rdata = model_view(bus_if.address);
    m_irq   = ((m_pend & m_mask) != '0);
    hit     = 1'b0;
    np      = '0;
    for (int i = 0; i < NS; i++) begin
      bit rising, cleared, flipped;
      flipped = we && (bus_if.address == 3'd2) && (bus_if.writedata[i] != m_mode[i]);
      cleared = we && (bus_if.address == 3'd0) && bus_if.writedata[i];
      rising  = m_armed && irq_in[i] && !m_prev[i];
      if (flipped) begin
        np[i] = 1'b0;
      end else if (!m_mode[i]) begin
        np[i] = irq_in[i];
      end else begin
        if (rising && m_pend[i] && !cleared) hit = 1'b1;
        np[i] = rising || (m_pend[i] && !cleared);
      end
    end
    if (hit) m_hits++;
`ifdef PROC_IRQ_AGG_LOST_CNT_EN
    if (we && bus_if.address == 3'd5) m_lost = 0;
    else if (hit && m_lost < 65535)   m_lost++;
`endif
    if (we && bus_if.address == 3'd1) m_mask = bus_if.writedata[NS-1:0];
    if (we && bus_if.address == 3'd2) m_mode = bus_if.writedata[NS-1:0];
    m_pend  = np;
    m_prev  = irq_in;
    m_armed = 1'b1;
  endtask

  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 16'h0000;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_idle();
    $display("wr addr=%0d data=0x%04h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
    $display("rd addr=%0d data=0x%04h", a, d);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [2:0]  zaddr [4];
    zaddr = '{3'd0, 3'd1, 3'd3, 3'd4};
    reset_n = 1'b0;
    irq_in  = '0;
    bus_if.address = 3'd2;
    bus_idle();
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_held: got %0b want 0", irq); end
    checks++; if (bus_if.readdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata_held: got 0x%04h want 0x0000", bus_if.readdata); end
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd2, d);
    checks++; if (d !== 16'((1 << NS) - 1)) begin errors++; $display("FAIL reset_mode: got 0x%04h want 0x%04h", d, 16'((1 << NS) - 1)); end
    for (int k = 0; k < 4; k++) begin
      rd(zaddr[k], d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_addr%0d: got 0x%04h want 0x0000", zaddr[k], d); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
  endtask

  task automatic test_edge_pulse();
    logic [15:0] d;
    wr(3'd1, 16'h0005);
    irq_in = 4'b0100;
    @(negedge clk);
    irq_in = '0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %0b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_latency: got %0b want 1", irq); end
    rd(3'd0, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL edge_pending: got 0x%04h want 0x0004", d); end
    rd(3'd4, d);
    checks++; if (d !== 16'h8002) begin errors++; $display("FAIL edge_vector: got 0x%04h want 0x8002", d); end
    wr(3'd0, 16'h0004);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_clear: got %0b want 0", irq); end
    rd(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_pending_clear: got 0x%04h want 0x0000", d); end
  endtask

  task automatic test_level();
    logic [15:0] d;
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0001);
    irq_in = 4'b0001;
    repeat (2) @(negedge clk);
    rd(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL level_pending: got 0x%04h want 0x0001", d); end
    wr(3'd0, 16'h0001);
    rd(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL level_w1c_held: got 0x%04h want 0x0001", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_irq_held: got %0b want 1", irq); end
    irq_in = '0;
    bus_if.address = 3'd0;
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_irq_1cyc: got %0b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_irq_drop: got %0b want 0", irq); end
    checks++; if (bus_if.readdata !== 16'h0000) begin errors++; $display("FAIL level_pending_drop: got 0x%04h want 0x0000", bus_if.readdata); end
    wr(3'd2, 16'h000F);
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_vector();
    logic [15:0] d;
    wr(3'd1, 16'h0003);
    irq_in = 4'b0011;
    @(negedge clk);
    irq_in = '0;
    @(negedge clk);
    rd(3'd4, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL vector_both: got 0x%04h want 0x8000", d); end
    wr(3'd0, 16'h0001);
    rd(3'd4, d);
    checks++; if (d !== 16'h8001) begin errors++; $display("FAIL vector_bit1: got 0x%04h want 0x8001", d); end
    wr(3'd0, 16'h0002);
    rd(3'd4, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL vector_none: got 0x%04h want 0x0000", d); end
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    irq_in = 4'b0010;
    @(negedge clk);
    irq_in = '0;
    @(negedge clk);
    irq_in = 4'b0010;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 16'h0002;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_idle();
    irq_in = '0;
    rd(3'd0, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL same_cycle_set_w1c: got 0x%04h want 0x0002", d); end
    wr(3'd0, 16'h0002);
    rd(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL same_cycle_cleanup: got 0x%04h want 0x0000", d); end
  endtask

  task automatic test_mode_change();
    logic [15:0] d;
    wr(3'd2, 16'h000E);
    irq_in = 4'b0001;
    repeat (2) @(negedge clk);
    rd(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL mode_level_pending: got 0x%04h want 0x0001", d); end
    wr(3'd2, 16'h000F);
    rd(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mode_change_clear: got 0x%04h want 0x0000", d); end
    repeat (3) @(negedge clk);
    rd(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mode_held_no_edge: got 0x%04h want 0x0000", d); end
    rd(3'd2, d);
    checks++; if (d !== 16'h000F) begin errors++; $display("FAIL mode_readback: got 0x%04h want 0x000F", d); end
    irq_in = '0;
    @(negedge clk);
  endtask

  task automatic test_lost();
    logic [15:0] d;
    logic [15:0] exp_lost;
`ifdef PROC_IRQ_AGG_LOST_CNT_EN
    exp_lost = 16'h0002;
`else
    exp_lost = 16'h0000;
`endif
    wr(3'd5, 16'h0000);
    wr(3'd0, 16'hFFFF);
    irq_in = 4'b1000;
    repeat (4) @(negedge clk);
    irq_in = '0;
    @(negedge clk);
    rd(3'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lost_held_high: got 0x%04h want 0x0000", d); end
    rd(3'd0, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL lost_single_set: got 0x%04h want 0x0008", d); end
    repeat (2) begin
      irq_in = 4'b1000;
      @(negedge clk);
      irq_in = '0;
      @(negedge clk);
    end
    rd(3'd5, d);
    checks++; if (d !== exp_lost) begin errors++; $display("FAIL lost_count: got 0x%04h want 0x%04h", d, exp_lost); end
    wr(3'd5, 16'h1234);
    rd(3'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lost_clear: got 0x%04h want 0x0000", d); end
    wr(3'd0, 16'h0008);
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    wr(3'd1, 16'h0001);
    irq_in = 4'b0001;
    @(negedge clk);
    irq_in = '0;
    bus_if.address = 3'd2;
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst_pre_irq: got %0b want 1", irq); end
    #2;
    reset_n = 1'b0;
    irq_in  = 4'b0001;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq_immediate: got %0b want 0", irq); end
    checks++; if (bus_if.readdata !== 16'h0000) begin errors++; $display("FAIL arst_rdata_immediate: got 0x%04h want 0x0000", bus_if.readdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_no_edge_at_release: got 0x%04h want 0x0000", d); end
    rd(3'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_mask: got 0x%04h want 0x0000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq_after: got %0b want 0", irq); end
    irq_in = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    reset_n = 1'b0;
    irq_in  = '0;
    bus_idle();
    @(negedge clk);
    m_pend  = '0;
    m_mask  = '0;
    m_mode  = '1;
    m_prev  = '0;
    m_armed = 1'b0;
    m_lost  = 0;
    m_hits  = 0;
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      irq_in            = irq_in ^ NS'($urandom & $urandom);
      bus_if.address    = 3'($urandom_range(0, 7));
      bus_if.chipselect = 1'($urandom_range(0, 1));
      bus_if.write_n    = 1'($urandom_range(0, 1));
      bus_if.writedata  = 16'($urandom);
      if (bus_if.chipselect && !bus_if.write_n)
        $display("rnd wr cyc=%0d addr=%0d data=0x%04h irq_in=0x%0h", c, bus_if.address, bus_if.writedata, irq_in);
      model_step();
      @(negedge clk);
      checks++; if (bus_if.readdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d: got 0x%04h want 0x%04h", c, bus_if.readdata, m_rdata); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc=%0d: got %0b want %0b", c, irq, m_irq); end
    end
    bus_idle();
    $display("random traffic done, lost events seen by model=%0d", m_hits);
  endtask

  initial begin
    reset_n = 1'b0;
    irq_in  = '0;
    bus_if.address = 3'd0;
    bus_idle();
    test_reset();
    test_edge_pulse();
    test_level();
    test_vector();
    test_back_to_back();
    test_mode_change();
    test_lost();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
